crc_serial_ctrl: RTL and testbench

//  Bit-serial CRC encoder controller. Sequences long division of one message by a

---
 rtl/crc_serial_ctrl.sv | 155 +++++++++++++++
 tb/tb_crc_serial_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_ctrl.sv
// ---------------------------------------------------------------------------
// crc_serial_ctrl
//
// Bit-serial CRC encoder controller. One message is accepted in IDLE, divided
// by a programmable generator polynomial one bit per clock over
// CW_W = MSG_W+GP_W-1 cycles, and the systematic codeword {msg, remainder}
// is then held on out_data until the consumer takes it.
//
// Parameters
//   MSG_W      message width in bits (>= 1)
//   GP_W       generator width including the implicit MSB (>= 3)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   message offered
//   in_ready   controller can accept a message (IDLE only)
//   in_data    message, MSB first
//   gp         generator polynomial, sampled at accept; gp[GP_W-1] taken as 1
//   out_valid  codeword available
//   out_ready  consumer takes codeword
//   out_data   codeword {msg, rem}
//   busy       high while a frame is in flight (SHIFT or DONE)
//   frame_cnt  saturating count of delivered frames
//
// Build option
//   CRC_FRAME_CNT_EN  when defined, adds the frame_cnt port and its counter.
// ---------------------------------------------------------------------------
module crc_serial_ctrl #(
  parameter int MSG_W = 5,
  parameter int GP_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MSG_W-1:0]         in_data,
  input  logic [GP_W-1:0]          gp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MSG_W+GP_W-2:0]    out_data,
`ifdef CRC_FRAME_CNT_EN
  output logic [15:0]              frame_cnt,
`endif
  output logic                     busy
);

  localparam int R     = GP_W - 1;
  localparam int CW_W  = MSG_W + GP_W - 1;
  localparam int CNT_W = $clog2(CW_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW_W-1:0]    shift_q, shift_d;
  logic [R-1:0]       rem_q, rem_d;
  logic [R-1:0]       gp_q, gp_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CW_W-1:0]    out_data_q, out_data_d;
  logic [R-1:0]       step_rem;

  // The generator MSB is implicit (always 1), so the port bit is never read.
  logic gp_msb_unused;
  assign gp_msb_unused = gp[GP_W-1];

  // One long-division step: shift the next dividend bit into the remainder
  // and subtract (XOR) the generator when the bit falling out was a 1.
  assign step_rem = {rem_q[R-2:0], shift_q[CW_W-1]} ^ (rem_q[R-1] ? gp_q : '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    rem_d      = rem_q;
    gp_d       = gp_q;
    msg_d      = msg_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SHIFT;
          shift_d = {in_data, {R{1'b0}}};
          msg_d   = in_data;
          gp_d    = gp[R-1:0];
          rem_d   = '0;
          cnt_d   = CNT_W'(CW_W);
        end
      end
      S_SHIFT: begin
        rem_d   = step_rem;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        // Last step: capture the final remainder straight from the step logic.
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_DONE;
          out_data_d = {msg_q, step_rem};
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      rem_q      <= '0;
      gp_q       <= '0;
      msg_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rem_q      <= rem_d;
      gp_q       <= gp_d;
      msg_q      <= msg_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;

`ifdef CRC_FRAME_CNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else if (out_valid && out_ready && (frame_q != 16'hFFFF)) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign frame_cnt = frame_q;
`endif

endmodule

// File: tb/tb_crc_serial_ctrl.sv
module tb_crc_serial_ctrl;

  localparam int MSG_W = 5;
  localparam int GP_W  = 3;
  localparam int R     = GP_W - 1;
  localparam int CW_W  = MSG_W + GP_W - 1;
  localparam int LAT   = CW_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [MSG_W-1:0]  in_data;
  logic [GP_W-1:0]   gp;
  logic              out_valid;
  logic              out_ready;
  logic [CW_W-1:0]   out_data;
  logic              busy;
`ifdef CRC_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [CW_W-1:0] sb_q[$];

  crc_serial_ctrl #(.MSG_W(MSG_W), .GP_W(GP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .gp        (gp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef CRC_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: polynomial long division of msg*x^R by {1, g[R-1:0]}.
  function automatic logic [CW_W-1:0] crc_ref(input logic [MSG_W-1:0] msg,
                                              input logic [GP_W-1:0] g);
    logic [CW_W-1:0] dividend;
    logic [GP_W-1:0] poly;
    poly     = {1'b1, g[R-1:0]};
    dividend = CW_W'(msg) << R;
    for (int i = CW_W - 1; i >= R; i--) begin
      if (dividend[i]) dividend = dividend ^ (CW_W'(poly) << (i - R));
    end
    return {msg, dividend[R-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [MSG_W-1:0] msg, input logic [GP_W-1:0] g,
                            input logic [CW_W-1:0] exp, input bit push);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_data  = msg;
    gp       = g;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (push) sb_q.push_back(exp);
  endtask

  // Wait for out_valid, counting edges since the accept edge, then compare
  // the codeword against the oldest scoreboard entry.
  task automatic wait_out(input string tag, input int start);
    int lat = start;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      check({tag, "_data"}, 64'(out_data), 64'(sb_q.pop_front()));
    end
  endtask

  initial begin
    logic [CW_W-1:0] held;
    logic [MSG_W-1:0] m;
    int hits;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    gp        = 3'b111;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);

    // Basic frame: one-cycle output pulse with out_ready held high.
    send_frame(5'b00001, 3'b111, 7'b0000111, 1'b1);
    check("busy_shift", 64'(busy), 64'd1);
    check("in_ready_shift", 64'(in_ready), 64'd0);
    wait_out("f1", 0);
    tick();
    check("f1_pulse_low", 64'(out_valid), 64'd0);
    check("f1_in_ready",  64'(in_ready),  64'd1);

    // Known codewords for gp=111.
    send_frame(5'b00010, 3'b111, 7'b0001001, 1'b1);
    wait_out("f2", 0);
    send_frame(5'b00011, 3'b111, 7'b0001110, 1'b1);
    wait_out("f3", 0);
    send_frame(5'b00000, 3'b111, 7'b0000000, 1'b1);
    wait_out("f0", 0);

    // Mixed generators and messages checked against the reference divider.
    for (int k = 0; k < 6; k++) begin
      logic [GP_W-1:0] g;
      m = MSG_W'($urandom);
      g = GP_W'($urandom);
      send_frame(m, g, crc_ref(m, g), 1'b1);
      wait_out("rand", 0);
    end
    send_frame(5'b11111, 3'b101, crc_ref(5'b11111, 3'b101), 1'b1);
    wait_out("ones_101", 0);

    // Backpressure: output held, inputs ignored, then a clean next frame.
    tick();
    out_ready = 1'b0;
    send_frame(5'b10110, 3'b111, crc_ref(5'b10110, 3'b111), 1'b1);
    held = crc_ref(5'b10110, 3'b111);
    wait_out("bp", 0);
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      in_data  = MSG_W'($urandom);
      gp       = GP_W'($urandom);
      tick();
      if (c % 5 == 4) begin
        check("bp_hold_data",  64'(out_data),  64'(held));
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_in_ready",   64'(in_ready),  64'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    send_frame(5'b01101, 3'b111, crc_ref(5'b01101, 3'b111), 1'b1);
    wait_out("bp_next", 0);

    // Input changes mid-SHIFT must not disturb the frame in flight.
    send_frame(5'b10011, 3'b111, crc_ref(5'b10011, 3'b111), 1'b1);
    tick();
    tick();
    gp       = 3'b101;
    in_data  = 5'b01010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("midshift", 3);

    // Reset mid-SHIFT aborts the frame with no output.
    tick();
    send_frame(5'b11001, 3'b111, '0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data",  64'(out_data),  64'd0);
    hits = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      tick();
      if (out_valid) hits++;
    end
    check("abort_no_output", 64'(hits), 64'd0);

`ifdef CRC_FRAME_CNT_EN
    check("fc_after_rst", 64'(frame_cnt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      m = MSG_W'(k + 4);
      send_frame(m, 3'b111, crc_ref(m, 3'b111), 1'b1);
      wait_out("fc_frame", 0);
    end
    tick();
    check("fc_three", 64'(frame_cnt), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("fc_cleared", 64'(frame_cnt), 64'd0);
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
